// File: rtl/im_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// im_port_arbiter_pkg
// Shared definitions for the instruction-memory port arbiter: word type,
// IM text-window base address, default index width, arbiter state encoding,
// grant-owner codes and a small address helper.
// -----------------------------------------------------------------------------
package im_port_arbiter_pkg;

  typedef logic [31:0] word_t;

  localparam word_t IM_BASE_ADDR = 32'h0000_3000;
  localparam int    IM_AW        = 13;

  typedef enum logic [1:0] {
    ST_SHARED = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_e;

  // A byte address is word-aligned when its two low bits are zero.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/im_port_arbiter_xlate.sv
// -----------------------------------------------------------------------------
// im_addr_xlate
// Combinational byte-address to IM word-index translation plus bad-address
// detection.
//   addr_i  : byte address (32 bits)
//   idx_o   : word index, (addr_i - BASE_ADDR) >> 2, truncated to AW bits
//   bad_o   : address cannot be serviced
// Configuration macro: IM_ARB_BOUNDS_CHK_EN
//   defined   : misaligned, below BASE_ADDR, or index >= 2**AW is bad
//   undefined : only misalignment is bad; the index wraps modulo 2**AW
// -----------------------------------------------------------------------------
module im_addr_xlate
  import im_port_arbiter_pkg::*;
#(
  parameter word_t BASE_ADDR = IM_BASE_ADDR,
  parameter int    AW        = IM_AW
) (
  input  word_t           addr_i,
  output logic [AW-1:0]   idx_o,
  output logic            bad_o
);

  word_t off_s;

  assign off_s = addr_i - BASE_ADDR;
  assign idx_o = off_s[AW+1:2];

`ifdef IM_ARB_BOUNDS_CHK_EN
  // Any offset bit above the index field means the word lies beyond the macro.
  assign bad_o = is_misaligned(addr_i[1:0]) | (addr_i < BASE_ADDR) | (|off_s[31:AW+2]);
`else
  // Upper offset bits are deliberately ignored so the index wraps.
  logic unused_off_hi_s;
  assign unused_off_hi_s = ^off_s[31:AW+2];
  assign bad_o = is_misaligned(addr_i[1:0]);
`endif

endmodule

// File: rtl/im_port_arbiter.sv
// -----------------------------------------------------------------------------
// im_port_arbiter
// Owns the single port of the 1-cycle synchronous-read instruction BRAM and
// shares it between the fetch stage (reads) and the program loader (word
// writes), with an exclusive load phase (SHARED -> DRAIN -> LOCKED).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req_i, if_addr_i             fetch request / byte address
//   if_gnt_o                        fetch accepted this cycle
//   if_rvalid_o, if_rdata_o, if_err_o  read return one cycle after grant
//   ld_req_i, ld_addr_i, ld_wdata_i loader write request / address / data
//   ld_lock_i                       loader asks for exclusive ownership
//   ld_gnt_o, ld_err_o              write accepted / dropped-write pulse
//   locked_o                        exclusive load phase active
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i  BRAM port
// Configuration macro: IM_ARB_BOUNDS_CHK_EN (range checking, see im_addr_xlate)
// -----------------------------------------------------------------------------
module im_port_arbiter
  import im_port_arbiter_pkg::*;
#(
  parameter word_t BASE_ADDR = IM_BASE_ADDR,
  parameter int    AW        = IM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [31:0]   if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_err_o,
  input  logic          ld_req_i,
  input  logic [31:0]   ld_addr_i,
  input  logic [31:0]   ld_wdata_i,
  input  logic          ld_lock_i,
  output logic          ld_gnt_o,
  output logic          ld_err_o,
  output logic          locked_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  logic [AW-1:0] if_idx_s, ld_idx_s;
  logic          if_bad_s, ld_bad_s;
  logic          if_gnt_s, ld_gnt_s;

  arb_state_e    state_q, state_d;
  owner_e        last_q, last_d;
  logic          rvalid_q, rerr_q, lderr_q;

  im_addr_xlate #(.BASE_ADDR(BASE_ADDR), .AW(AW)) u_if_xlate (
    .addr_i (if_addr_i),
    .idx_o  (if_idx_s),
    .bad_o  (if_bad_s)
  );

  im_addr_xlate #(.BASE_ADDR(BASE_ADDR), .AW(AW)) u_ld_xlate (
    .addr_i (ld_addr_i),
    .idx_o  (ld_idx_s),
    .bad_o  (ld_bad_s)
  );

  // Grant selection and next-state: grants are decided in the request cycle.
  always_comb begin
    if_gnt_s = 1'b0;
    ld_gnt_s = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    case (state_q)
      ST_SHARED: begin
        if (ld_lock_i) begin
          // Lock request wins over everything; nothing is granted this cycle.
          state_d = ST_DRAIN;
        end else if (if_req_i && ld_req_i) begin
          if (last_q == OWN_FETCH) begin
            ld_gnt_s = 1'b1;
            last_d   = OWN_LOAD;
          end else begin
            if_gnt_s = 1'b1;
            last_d   = OWN_FETCH;
          end
        end else if (if_req_i) begin
          if_gnt_s = 1'b1;
          last_d   = OWN_FETCH;
        end else if (ld_req_i) begin
          ld_gnt_s = 1'b1;
          last_d   = OWN_LOAD;
        end else begin
          last_d = last_q;
        end
      end
      ST_DRAIN: begin
        // The only possible in-flight read returns during the entry cycle.
        if (ld_lock_i) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_SHARED;
        end
      end
      ST_LOCKED: begin
        ld_gnt_s = ld_req_i;
        // Leaving the lock hands priority to fetch for the first conflict.
        last_d   = OWN_LOAD;
        if (ld_lock_i) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_SHARED;
        end
      end
      default: begin
        state_d = ST_SHARED;
        last_d  = OWN_FETCH;
      end
    endcase
  end

  // Arbiter state, priority history and read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SHARED;
      last_q   <= OWN_FETCH;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      lderr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= if_gnt_s;
      rerr_q   <= if_gnt_s & if_bad_s;
      lderr_q  <= ld_gnt_s & ld_bad_s;
    end
  end

  assign if_gnt_o    = if_gnt_s;
  assign ld_gnt_o    = ld_gnt_s;
  assign if_rvalid_o = rvalid_q;
  assign if_err_o    = rerr_q;
  assign if_rdata_o  = (rvalid_q && !rerr_q) ? mem_rdata_i : 32'h0000_0000;
  assign ld_err_o    = lderr_q;
  assign locked_o    = (state_q == ST_LOCKED);

  // A dropped write still takes its grant but never touches the macro.
  assign mem_we_o    = (ld_gnt_s && !ld_bad_s) ? 4'hF : 4'h0;
  assign mem_addr_o  = ld_gnt_s ? ld_idx_s : if_idx_s;
  assign mem_wdata_o = ld_wdata_i;

endmodule

// File: tb/tb_im_port_arbiter.sv
module tb_im_port_arbiter;

  localparam logic [31:0] TB_BASE = 32'h0000_3000;
  localparam int          TB_AW   = 13;
  localparam int          DEPTH   = 8192;
`ifdef IM_ARB_BOUNDS_CHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic              clk, rst_n;
  logic              if_req, if_gnt, if_rvalid, if_err;
  logic [31:0]       if_addr, if_rdata;
  logic              ld_req, ld_lock, ld_gnt, ld_err, locked;
  logic [31:0]       ld_addr, ld_wdata;
  logic [3:0]        mem_we;
  logic [TB_AW-1:0]  mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  im_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_lock_i(ld_lock),
    .ld_gnt_o(ld_gnt), .ld_err_o(ld_err), .locked_o(locked),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-in: one-cycle synchronous read, word writes
  logic [31:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_we == 4'hF) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          phase;        // 0 shared, 1 draining, 2 exclusive load
  bit          fetch_first;  // fetch wins the next simultaneous request
  bit          pv, pe, ple;
  logic [31:0] pd;
  logic [31:0] shadow [DEPTH];

  function automatic bit m_bad(input logic [31:0] a);
    logic [31:0] d;
    bit b;
    d = a - TB_BASE;
    b = (a % 32'd4) != 32'd0;
    if (BCHK && (a < TB_BASE || (d / 32'd4) >= DEPTH)) b = 1'b1;
    return b;
  endfunction

  function automatic int unsigned m_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - TB_BASE;
    return (d / 32'd4) % DEPTH;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + i * 32'h0001_0101;
  endfunction

  task automatic model_reset();
    phase = 0; fetch_first = 1'b0; pv = 1'b0; pe = 1'b0; ple = 1'b0; pd = 32'h0;
  endtask

  bit obs_ig, obs_lg, obs_rv, obs_er, obs_lk, obs_le;
  logic [3:0]  obs_we;
  logic [12:0] obs_ma;

  // Apply one cycle of inputs, compare against the model at negedge, advance.
  task automatic step(input bit ifr, input logic [31:0] ifa, input bit ldr,
                      input logic [31:0] lda, input logic [31:0] ldw, input bit lck);
    bit m_ig, m_lg, bi, bl;
    int unsigned xi, xl;
    if_req = ifr; if_addr = ifa; ld_req = ldr; ld_addr = lda; ld_wdata = ldw; ld_lock = lck;
    @(negedge clk);
    bi = m_bad(ifa); bl = m_bad(lda); xi = m_idx(ifa); xl = m_idx(lda);
    m_ig = 1'b0; m_lg = 1'b0;
    if (phase == 0 && !lck) begin
      if (ifr && ldr) begin m_ig = fetch_first; m_lg = !fetch_first; end
      else begin m_ig = ifr; m_lg = ldr; end
    end else if (phase == 2) begin
      m_lg = ldr;
    end
    obs_ig = if_gnt; obs_lg = ld_gnt; obs_rv = if_rvalid; obs_er = if_err;
    obs_lk = locked; obs_le = ld_err; obs_we = mem_we; obs_ma = mem_addr;
    chk("m_if_gnt", {31'd0, if_gnt}, {31'd0, m_ig});
    chk("m_ld_gnt", {31'd0, ld_gnt}, {31'd0, m_lg});
    chk("m_if_rvalid", {31'd0, if_rvalid}, {31'd0, pv});
    if (pv) begin
      chk("m_if_err", {31'd0, if_err}, {31'd0, pe});
      chk("m_if_rdata", if_rdata, pe ? 32'h0 : pd);
    end
    chk("m_ld_err", {31'd0, ld_err}, {31'd0, ple});
    chk("m_locked", {31'd0, locked}, {31'd0, phase == 2});
    chk("m_mem_we", {28'd0, mem_we}, (m_lg && !bl) ? 32'hF : 32'h0);
    if (m_lg && !bl) begin
      chk("m_wr_addr", {19'd0, mem_addr}, xl);
      chk("m_wr_data", mem_wdata, ldw);
    end
    if (m_ig && !bi) chk("m_rd_addr", {19'd0, mem_addr}, xi);
    @(posedge clk);
    pv = m_ig; pe = bi; pd = shadow[xi]; ple = m_lg && bl;
    if (m_lg && !bl) shadow[xl] = ldw;
    if (m_ig) fetch_first = 1'b0;
    if (m_lg) fetch_first = 1'b1;
    case (phase)
      0: phase = lck ? 1 : 0;
      1: phase = lck ? 2 : 0;
      default: begin
        if (!lck) fetch_first = 1'b1;
        phase = lck ? 2 : 0;
      end
    endcase
    #1;
  endtask

  function automatic logic [31:0] gen_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return TB_BASE + 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
    if (r == 1) return 32'h0000_B000 + 4 * $urandom_range(0, 7);
    if (r == 2) return 32'h0000_2F00 + 4 * $urandom_range(0, 63);
    return TB_BASE + 4 * $urandom_range(0, 63);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit ifr; logic [31:0] ifa; bit ldr; logic [31:0] lda; logic [31:0] ldw; bit lck;
    bit e_ig; bit e_lg; bit e_rv; bit e_er; bit e_lk; bit e_le;
    bit e_mchk; logic [12:0] e_ma; bit e_we;
  } vec_t;

  function automatic vec_t mkv(bit ifr, logic [31:0] ifa, bit ldr, logic [31:0] lda,
                               logic [31:0] ldw, bit lck, bit ig, bit lg, bit rv, bit er,
                               bit lk, bit le, bit mchk, logic [12:0] ma, bit we);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.ldr = ldr; v.lda = lda; v.ldw = ldw; v.lck = lck;
    v.e_ig = ig; v.e_lg = lg; v.e_rv = rv; v.e_er = er; v.e_lk = lk; v.e_le = le;
    v.e_mchk = mchk; v.e_ma = ma; v.e_we = we;
    return v;
  endfunction

  localparam logic [31:0] Z = 32'h0;
  vec_t tv [29];

  initial begin
    bit lck_r;
    // fetch stream, round-robin in both orders, data read back from a write
    tv[0]  = mkv(1, 32'h3000, 0, Z, Z, 0,            1, 0, 0, 0, 0, 0, 1, 13'h000, 0);
    tv[1]  = mkv(1, 32'h3004, 0, Z, Z, 0,            1, 0, 1, 0, 0, 0, 1, 13'h001, 0);
    tv[2]  = mkv(1, 32'h3008, 0, Z, Z, 0,            1, 0, 1, 0, 0, 0, 1, 13'h002, 0);
    tv[3]  = mkv(0, Z, 0, Z, Z, 0,                   0, 0, 1, 0, 0, 0, 0, 13'h000, 0);
    tv[4]  = mkv(1, 32'h300C, 1, 32'h3100, 32'hDEAD_0001, 0, 0, 1, 0, 0, 0, 0, 1, 13'h040, 1);
    tv[5]  = mkv(1, 32'h300C, 1, 32'h3100, 32'hDEAD_0001, 0, 1, 0, 0, 0, 0, 0, 1, 13'h003, 0);
    tv[6]  = mkv(1, 32'h3010, 1, 32'h3104, 32'hDEAD_0002, 0, 0, 1, 1, 0, 0, 0, 1, 13'h041, 1);
    tv[7]  = mkv(1, 32'h3010, 1, 32'h3104, 32'hDEAD_0002, 0, 1, 0, 0, 0, 0, 0, 1, 13'h004, 0);
    tv[8]  = mkv(1, 32'h3100, 0, Z, Z, 0,            1, 0, 1, 0, 0, 0, 1, 13'h040, 0);
    // lock raised with fetch 0x3010 in flight, writes at 0x4180.., bad write, lock drop
    tv[9]  = mkv(1, 32'h3010, 0, Z, Z, 0,            1, 0, 1, 0, 0, 0, 1, 13'h004, 0);
    tv[10] = mkv(1, 32'h3014, 1, 32'h4180, 32'hC0DE_0000, 1, 0, 0, 1, 0, 0, 0, 0, 13'h000, 0);
    tv[11] = mkv(1, 32'h3014, 1, 32'h4180, 32'hC0DE_0000, 1, 0, 0, 0, 0, 0, 0, 0, 13'h000, 0);
    tv[12] = mkv(1, 32'h3014, 1, 32'h4180, 32'hC0DE_0000, 1, 0, 1, 0, 0, 1, 0, 1, 13'h460, 1);
    tv[13] = mkv(1, 32'h3014, 1, 32'h4184, 32'hC0DE_0001, 1, 0, 1, 0, 0, 1, 0, 1, 13'h461, 1);
    tv[14] = mkv(1, 32'h3014, 1, 32'h3001, 32'hBAD0_BAD0, 1, 0, 1, 0, 0, 1, 0, 0, 13'h000, 0);
    tv[15] = mkv(1, 32'h3014, 0, Z, Z, 1,            0, 0, 0, 0, 1, 1, 0, 13'h000, 0);
    tv[16] = mkv(1, 32'h3014, 1, 32'h4188, 32'hC0DE_0002, 0, 0, 1, 0, 0, 1, 0, 1, 13'h462, 1);
    tv[17] = mkv(1, 32'h3014, 1, 32'h418C, 32'hC0DE_0003, 0, 1, 0, 0, 0, 0, 0, 1, 13'h005, 0);
    tv[18] = mkv(0, Z, 1, 32'h418C, 32'hC0DE_0003, 0, 0, 1, 1, 0, 0, 0, 1, 13'h463, 1);
    // misaligned fetch, lock dropped during drain, range boundaries
    tv[19] = mkv(1, 32'h3002, 0, Z, Z, 0,            1, 0, 0, 0, 0, 0, 0, 13'h000, 0);
    tv[20] = mkv(1, 32'h4180, 0, Z, Z, 0,            1, 0, 1, 1, 0, 0, 1, 13'h460, 0);
    tv[21] = mkv(0, Z, 0, Z, Z, 0,                   0, 0, 1, 0, 0, 0, 0, 13'h000, 0);
    tv[22] = mkv(0, Z, 0, Z, Z, 1,                   0, 0, 0, 0, 0, 0, 0, 13'h000, 0);
    tv[23] = mkv(1, 32'h3000, 0, Z, Z, 0,            0, 0, 0, 0, 0, 0, 0, 13'h000, 0);
    tv[24] = mkv(1, 32'h3000, 0, Z, Z, 0,            1, 0, 0, 0, 0, 0, 1, 13'h000, 0);
    tv[25] = mkv(1, 32'hB000, 0, Z, Z, 0,            1, 0, 1, 0, 0, 0, !BCHK, 13'h000, 0);
    tv[26] = mkv(0, Z, 0, Z, Z, 0,                   0, 0, 1, BCHK, 0, 0, 0, 13'h000, 0);
    tv[27] = mkv(1, 32'h2FFC, 0, Z, Z, 0,            1, 0, 0, 0, 0, 0, !BCHK, 13'h1FFF, 0);
    tv[28] = mkv(0, Z, 0, Z, Z, 0,                   0, 0, 1, BCHK, 0, 0, 0, 13'h000, 0);

    for (int i = 0; i < DEPTH; i++) begin
      bram[i] = init_word(i);
      shadow[i] = init_word(i);
    end
    if_req = 0; if_addr = 0; ld_req = 0; ld_addr = 0; ld_wdata = 0; ld_lock = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_if_err", {31'd0, if_err}, 32'd0);
    chk("rst_ld_err", {31'd0, ld_err}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(tv[i].ifr, tv[i].ifa, tv[i].ldr, tv[i].lda, tv[i].ldw, tv[i].lck);
      chk($sformatf("tv%0d_if_gnt", i), {31'd0, obs_ig}, {31'd0, tv[i].e_ig});
      chk($sformatf("tv%0d_ld_gnt", i), {31'd0, obs_lg}, {31'd0, tv[i].e_lg});
      chk($sformatf("tv%0d_rvalid", i), {31'd0, obs_rv}, {31'd0, tv[i].e_rv});
      if (tv[i].e_rv) chk($sformatf("tv%0d_if_err", i), {31'd0, obs_er}, {31'd0, tv[i].e_er});
      chk($sformatf("tv%0d_locked", i), {31'd0, obs_lk}, {31'd0, tv[i].e_lk});
      chk($sformatf("tv%0d_ld_err", i), {31'd0, obs_le}, {31'd0, tv[i].e_le});
      chk($sformatf("tv%0d_mem_we", i), {28'd0, obs_we}, tv[i].e_we ? 32'hF : 32'h0);
      if (tv[i].e_mchk) chk($sformatf("tv%0d_mem_addr", i), {19'd0, obs_ma}, {19'd0, tv[i].e_ma});
    end

    // reset in the cycle after a fetch grant: the read must vanish
    step(1, 32'h3008, 0, Z, Z, 0);
    rst_n = 1'b0; if_req = 0; ld_lock = 1;
    model_reset();
    @(negedge clk);
    chk("rstmid_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rstmid_locked", {31'd0, locked}, 32'd0);
    @(negedge clk);
    chk("rstmid_locked2", {31'd0, locked}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, Z, 0, Z, Z, 0);
    chk("rstpost_rvalid", {31'd0, obs_rv}, 32'd0);

    // reset from inside the exclusive phase
    step(0, Z, 0, Z, Z, 1);
    step(0, Z, 0, Z, Z, 1);
    step(0, Z, 1, 32'h3020, 32'h1234_5678, 1);
    chk("lock_reached", {31'd0, obs_lk}, 32'd1);
    rst_n = 1'b0; ld_req = 0;
    model_reset();
    @(negedge clk);
    chk("rstlock_locked", {31'd0, locked}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, Z, 0, Z, Z, 0);
    chk("rstlock_after", {31'd0, obs_lk}, 32'd0);

    // randomized traffic against the model
    lck_r = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 11) == 0) lck_r = ~lck_r;
      step($urandom_range(0, 3) != 0, gen_addr(), $urandom_range(0, 2) == 0,
           gen_addr(), $urandom, lck_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
